// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock,
// with divide-by-zero shortcut, annul (flush) and a combinational stall request.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  annul,
  input  logic                  signed_div,
  input  logic [DATA_W-1:0]     opdata1,
  input  logic [DATA_W-1:0]     opdata2,
  output logic [2*DATA_W-1:0]   result,
  output logic                  ready,
  output logic                  stall_req
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  localparam logic [DATA_W-1:0]   ZERO_W  = {DATA_W{1'b0}};
  localparam logic [2*DATA_W-1:0] ZERO_2W = {(2*DATA_W){1'b0}};

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return (~v) + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic            is_signed);
    logic [DATA_W-1:0] m;
    if (is_signed && v[DATA_W-1]) begin
      m = negate(v);
    end else begin
      m = v;
    end
    return m;
  endfunction

  logic [1:0]          state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [DATA_W-1:0]   rem_q,    rem_d;
  logic [DATA_W-1:0]   quo_q,    quo_d;
  logic [DATA_W-1:0]   dvsr_q,   dvsr_d;
  logic                sign1_q,  sign1_d;
  logic                sign2_q,  sign2_d;
  logic                sdiv_q,   sdiv_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q,  ready_d;

  logic [DATA_W:0]     rem_sh_s;
  logic                fits_s;
  logic [DATA_W-1:0]   rem_nx_s;
  logic [DATA_W-1:0]   quo_nx_s;
  logic [DATA_W-1:0]   quo_fix_s;
  logic [DATA_W-1:0]   rem_fix_s;

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    rem_sh_s = {rem_q, quo_q[DATA_W-1]};
    fits_s   = (rem_sh_s >= {1'b0, dvsr_q});
    if (fits_s) begin
      rem_nx_s = rem_sh_s[DATA_W-1:0] - dvsr_q;
    end else begin
      rem_nx_s = rem_sh_s[DATA_W-1:0];
    end
    quo_nx_s = {quo_q[DATA_W-2:0], fits_s};
    if (sdiv_q && (sign1_q ^ sign2_q)) begin
      quo_fix_s = negate(quo_nx_s);
    end else begin
      quo_fix_s = quo_nx_s;
    end
    // Remainder takes the dividend's sign.
    if (sdiv_q && sign1_q) begin
      rem_fix_s = negate(rem_nx_s);
    end else begin
      rem_fix_s = rem_nx_s;
    end
  end

  // Sequencer: accept, iterate, publish result, and handle annul.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    sdiv_d   = sdiv_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      S_IDLE: begin
        result_d = ZERO_2W;
        ready_d  = 1'b0;
        if (start && !annul) begin
          if (opdata2 == ZERO_W) begin
            state_d = S_BYZERO;
          end else begin
            state_d = S_ON;
            cnt_d   = {CNT_W{1'b0}};
            rem_d   = ZERO_W;
            quo_d   = magnitude(opdata1, signed_div);
            dvsr_d  = magnitude(opdata2, signed_div);
            sign1_d = opdata1[DATA_W-1];
            sign2_d = opdata2[DATA_W-1];
            sdiv_d  = signed_div;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BYZERO: begin
        if (annul) begin
          state_d  = S_IDLE;
          result_d = ZERO_2W;
          ready_d  = 1'b0;
        end else begin
          state_d  = S_END;
          result_d = ZERO_2W;
          ready_d  = 1'b1;
        end
      end
      S_ON: begin
        if (annul) begin
          state_d  = S_IDLE;
          result_d = ZERO_2W;
          ready_d  = 1'b0;
        end else begin
          rem_d = rem_nx_s;
          quo_d = quo_nx_s;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d  = S_END;
            result_d = {rem_fix_s, quo_fix_s};
            ready_d  = 1'b1;
          end else begin
            state_d = S_ON;
          end
        end
      end
      S_END: begin
        if (annul || !start) begin
          state_d  = S_IDLE;
          result_d = ZERO_2W;
          ready_d  = 1'b0;
        end else begin
          state_d = S_END;
        end
      end
      default: begin
        state_d  = S_IDLE;
        result_d = ZERO_2W;
        ready_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      rem_q    <= ZERO_W;
      quo_q    <= ZERO_W;
      dvsr_q   <= ZERO_W;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      sdiv_q   <= 1'b0;
      result_q <= ZERO_2W;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      sdiv_q   <= sdiv_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result    = result_q;
  assign ready     = ready_q;
  assign stall_req = start & ~ready_q & ~annul;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: unsigned/signed divides, divide-by-zero,
// overflow, annul, asynchronous reset and operand changes mid-operation.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        annul;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;
  logic        stall_req;

  int checks;
  int errors;

  div_unit #(.DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .annul      (annul),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .result     (result),
    .ready      (ready),
    .stall_req  (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called just after a negedge: raises start, counts edges (accept edge = 1) until ready.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit scramble, output int lat, output logic [63:0] res,
                         output bit sok);
    opdata1    = a;
    opdata2    = b;
    signed_div = s;
    start      = 1'b1;
    lat = 0;
    sok = 1'b1;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (scramble && lat == 5) begin
        opdata1 = 32'hDEADBEEF;
        opdata2 = 32'h00000003;
      end
      if (ready) break;
      if (!stall_req) sok = 1'b0;
    end
    res = result;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = 32'h0; opdata2 = 32'h0;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_req); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divu();
    int lat; logic [63:0] res; bit sok;
    opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    #1;
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL divu_stall_pre got %b want 1", stall_req); end
    run_div(32'd100, 32'd7, 1'b0, 1'b0, lat, res, sok);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency got %0d want 33", lat); end
    checks++; if (sok !== 1'b1) begin errors++; $display("FAIL divu_stall_during got %b want 1", sok); end
    checks++; if (res !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_100_7 got %h want %h", res, {32'd2, 32'd14}); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL divu_stall_post got %b want 0", stall_req); end
    @(negedge clk);
    checks++; if (ready !== 1'b1 || result !== {32'd2, 32'd14}) begin
      errors++; $display("FAIL divu_hold got ready=%b result=%h want 1 %h", ready, result, {32'd2, 32'd14}); end
    start = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b0 || result !== 64'h0) begin
      errors++; $display("FAIL divu_release got ready=%b result=%h want 0 0", ready, result); end
  endtask

  task automatic test_signed();
    int lat; logic [63:0] res; bit sok;
    run_div(32'hFFFFFFF9, 32'h2, 1'b1, 1'b0, lat, res, sok);
    checks++; if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin errors++; $display("FAIL div_m7_2 got %h want ffffffff_fffffffd", res); end
    start = 1'b0; @(negedge clk);
    run_div(32'h7, 32'hFFFFFFFE, 1'b1, 1'b0, lat, res, sok);
    checks++; if (res !== {32'h1, 32'hFFFFFFFD}) begin errors++; $display("FAIL div_7_m2 got %h want 00000001_fffffffd", res); end
    start = 1'b0; @(negedge clk);
    run_div(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 1'b0, lat, res, sok);
    checks++; if (res !== {32'hFFFFFFFE, 32'd14}) begin errors++; $display("FAIL div_m100_m7 got %h want fffffffe_0000000e", res); end
    start = 1'b0; @(negedge clk);
    run_div(32'hFFFFFFF9, 32'h2, 1'b0, 1'b0, lat, res, sok);
    checks++; if (res !== {32'h1, 32'h7FFFFFFC}) begin errors++; $display("FAIL divu_fff9_2 got %h want 00000001_7ffffffc", res); end
    start = 1'b0; @(negedge clk);
  endtask

  task automatic test_byzero();
    int lat; logic [63:0] res; bit sok;
    run_div(32'd5, 32'd0, 1'b0, 1'b0, lat, res, sok);
    checks++; if (lat !== 2) begin errors++; $display("FAIL byzero_latency got %0d want 2", lat); end
    checks++; if (res !== 64'h0) begin errors++; $display("FAIL byzero_result got %h want 0", res); end
    start = 1'b0; @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL byzero_release got %b want 0", ready); end
  endtask

  task automatic test_boundary();
    int lat; logic [63:0] res; bit sok;
    run_div(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, lat, res, sok);
    checks++; if (res !== {32'h0, 32'hFFFFFFFF}) begin errors++; $display("FAIL divu_max_1 got %h want 00000000_ffffffff", res); end
    start = 1'b0; @(negedge clk);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, lat, res, sok);
    checks++; if (res !== {32'h0, 32'h80000000}) begin errors++; $display("FAIL div_overflow got %h want 00000000_80000000", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_overflow_latency got %0d want 33", lat); end
    start = 1'b0; @(negedge clk);
  endtask

  task automatic test_annul();
    int lat; logic [63:0] res; bit sok; bit seen;
    opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL annul_stall got %b want 0", stall_req); end
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL annul_no_ready got %b want 0", seen); end
    run_div(32'd9, 32'd3, 1'b0, 1'b0, lat, res, sok);
    checks++; if (res !== {32'd0, 32'd3} || lat !== 33) begin
      errors++; $display("FAIL annul_then_9_3 got %h lat %0d want 00000000_00000003 lat 33", res, lat); end
    start = 1'b0; @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat; logic [63:0] res; bit sok;
    opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (16) @(negedge clk);
    reset = 1'b1; start = 1'b0;
    #1;
    checks++; if (ready !== 1'b0 || result !== 64'h0) begin
      errors++; $display("FAIL rst_mid got ready=%b result=%h want 0 0", ready, result); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_div(32'd100, 32'd7, 1'b0, 1'b1, lat, res, sok);
    checks++; if (res !== {32'd2, 32'd14} || lat !== 33) begin
      errors++; $display("FAIL rst_then_scrambled got %h lat %0d want 00000002_0000000e lat 33", res, lat); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (ready !== 1'b0 || result !== 64'h0) begin
      errors++; $display("FAIL rst_async_end got ready=%b result=%h want 0 0", ready, result); end
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_divu();
    test_signed();
    test_byzero();
    test_boundary();
    test_annul();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
